// File: rtl/merger_tree_param.sv
// merger_tree_param: LEAVES-way binary merge tree combining ascending sorted streams into one,
// with an all-ones terminator (TERM) marking the end of each stream.
module merger_tree_param #(
  parameter int DATA_W     = 32,
  parameter int LEAVES     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [LEAVES*DATA_W-1:0] i_fifo,
  input  logic [LEAVES-1:0]        i_fifo_empty,
  input  logic                     i_fifo_out_ready,
  output logic [LEAVES-1:0]        o_fifo_read,
  output logic                     o_out_fifo_write,
  output logic [DATA_W-1:0]        o_data,
  output logic [31:0]              o_count,
  output logic                     o_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] TERM = '1;
  genvar n;
  // Heap numbering: node n merges children 2n and 2n+1; indices >= LEAVES are the external
  // leaf FIFOs, and every node n > 1 owns the FIFO carrying its output up to node n/2.
  for (n = 1; n < LEAVES; n++) begin : g_node
    logic [DATA_W-1:0] a, b, emit;
    logic a_empty, b_empty, ready, fire, pop_a, pop_b;
    if (2 * n < LEAVES) begin : g_in
      assign a       = g_node[2*n].g_fifo.q_data;
      assign a_empty = g_node[2*n].g_fifo.q_empty;
      assign b       = g_node[2*n+1].g_fifo.q_data;
      assign b_empty = g_node[2*n+1].g_fifo.q_empty;
    end else begin : g_in
      assign a       = i_fifo[(2*n-LEAVES)*DATA_W +: DATA_W];
      assign a_empty = i_fifo_empty[2*n-LEAVES];
      assign b       = i_fifo[(2*n+1-LEAVES)*DATA_W +: DATA_W];
      assign b_empty = i_fifo_empty[2*n+1-LEAVES];
      assign o_fifo_read[2*n-LEAVES]   = pop_a;
      assign o_fifo_read[2*n+1-LEAVES] = pop_b;
    end
    assign fire  = i_rst_n & ~a_empty & ~b_empty & ready;
    // Ties favour input A; two terminators collapse into a single emitted TERM.
    assign pop_a = fire & (a <= b);
    assign pop_b = fire & ((b < a) | ((a == TERM) & (b == TERM)));
    assign emit  = (a <= b) ? a : b;
    if (n > 1) begin : g_fifo
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [DATA_W-1:0] q_data;
      logic [AW:0] wp, rp;
      logic q_empty, full, rd;
      assign rd      = (n % 2 == 1) ? g_node[n/2].pop_b : g_node[n/2].pop_a;
      assign q_empty = wp == rp;
      assign full    = (wp ^ rp) == {1'b1, {AW{1'b0}}};
      assign q_data  = mem[rp[AW-1:0]];
      assign ready   = ~full | rd;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          wp <= '0;
          rp <= '0;
        end else begin
          wp <= fire ? wp + 1'b1 : wp;
          rp <= rd ? rp + 1'b1 : rp;
        end
      end
      // A full FIFO is written only while its head slot is being read on the same edge.
      always_ff @(posedge i_clk) begin
        if (fire) mem[wp[AW-1:0]] <= emit;
      end
    end else begin : g_root
      assign ready = i_fifo_out_ready & ~o_done;
    end
  end
  assign o_out_fifo_write = g_node[1].fire;
  assign o_data           = g_node[1].emit;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_count <= '0;
      o_done  <= 1'b0;
    end else if (o_out_fifo_write) begin
      o_done  <= o_done | (o_data == TERM);
      o_count <= (o_data == TERM) ? o_count : o_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_merger_tree_param.sv
// tb_merger_tree_param: directed bench for the merge tree, a 4-leaf instance and an 8-leaf
// instance with shallow internal FIFOs, driven from show-ahead leaf FIFO models.
module tb_merger_tree_param;
  localparam logic [31:0] T = '1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst4 = 1'b0, rst8 = 1'b0, rdy4 = 1'b1, rdy8 = 1'b1;
  logic [127:0] fifo4;
  logic [3:0] emp4, rd4;
  logic wr4, done4;
  logic [31:0] data4, count4;
  logic [255:0] fifo8;
  logic [7:0] emp8, rd8;
  logic wr8, done8;
  logic [31:0] data8, count8;
  merger_tree_param #(.DATA_W(32), .LEAVES(4), .FIFO_DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst4), .i_fifo(fifo4), .i_fifo_empty(emp4),
    .i_fifo_out_ready(rdy4), .o_fifo_read(rd4), .o_out_fifo_write(wr4),
    .o_data(data4), .o_count(count4), .o_done(done4));
  merger_tree_param #(.DATA_W(32), .LEAVES(8), .FIFO_DEPTH(2)) dut8 (
    .i_clk(clk), .i_rst_n(rst8), .i_fifo(fifo8), .i_fifo_empty(emp8),
    .i_fifo_out_ready(rdy8), .o_fifo_read(rd8), .o_out_fifo_write(wr8),
    .o_data(data8), .o_count(count8), .o_done(done8));
  // Internal FIFO monitors: overflow/underflow flags and occupancy.
  logic [3:2] bad4;
  logic [7:2] bad8;
  logic [2:0] lvl4 [2:3];
  for (genvar g = 2; g < 4; g++) begin : g_m4
    assign bad4[g] = (dut4.g_node[g].fire & dut4.g_node[g].g_fifo.full & ~dut4.g_node[g].g_fifo.rd)
                   | (dut4.g_node[g].g_fifo.rd & dut4.g_node[g].g_fifo.q_empty);
    assign lvl4[g] = dut4.g_node[g].g_fifo.wp - dut4.g_node[g].g_fifo.rp;
  end
  for (genvar g = 2; g < 8; g++) begin : g_m8
    assign bad8[g] = (dut8.g_node[g].fire & dut8.g_node[g].g_fifo.full & ~dut8.g_node[g].g_fifo.rd)
                   | (dut8.g_node[g].g_fifo.rd & dut8.g_node[g].g_fifo.q_empty);
  end
  logic [31:0] s4 [4][18];
  logic [31:0] s8 [8][18];
  int p4 [4], n4 [4], p8 [8], n8 [8];
  logic [31:0] out4 [$], out8 [$], want [$];
  int checks = 0, failures = 0;
  int ovf4 = 0, ovf8 = 0, since4 = 0, since8 = 0, first4 = -1, first8 = -1, tie1 = -1, tie3 = -1;
  bit rnd8 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      fifo4[k*32 +: 32] = (p4[k] < n4[k]) ? s4[k][p4[k]] : '0;
      emp4[k] = p4[k] >= n4[k];
    end
    for (int k = 0; k < 8; k++) begin
      fifo8[k*32 +: 32] = (p8[k] < n8[k]) ? s8[k][p8[k]] : '0;
      emp8[k] = p8[k] >= n8[k];
    end
  endtask

  // Sample at the falling edge, then apply leaf pops just after the rising edge.
  task automatic tick();
    logic [3:0] r4;
    logic [7:0] r8;
    @(negedge clk);
    r4 = rd4;
    r8 = rd8;
    if (wr4) out4.push_back(data4);
    if (wr8) out8.push_back(data8);
    if (wr4 && first4 < 0) first4 = since4;
    if (wr8 && first8 < 0) first8 = since8;
    since4++;
    since8++;
    if (r4[1] && tie1 < 0) tie1 = p4[0];
    if (r4[3] && tie3 < 0) tie3 = p4[2];
    if (|bad4) ovf4++;
    if (|bad8) ovf8++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (r4[k]) p4[k]++;
    for (int k = 0; k < 8; k++) if (r8[k]) p8[k]++;
    if (rnd8) rdy8 = (first8 >= 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    drive();
  endtask

  task automatic load_std();
    for (int k = 0; k < 4; k++) begin
      s4[k][0] = 32'(k + 1);
      s4[k][1] = 32'(k + 5);
      s4[k][2] = T;
      n4[k] = 3;
      p4[k] = 0;
    end
    drive();
  endtask

  task automatic hold4();
    rst4 = 1'b0;
    tick();
  endtask

  task automatic go4();
    tick();
    rst4 = 1'b1;
    since4 = 0;
    first4 = -1;
    out4.delete();
  endtask

  task automatic run4(input string tag, input int budget);
    int c = 0;
    while (done4 !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_done"}, 64'(done4), 64'd1);
    repeat (4) tick();
  endtask

  task automatic check_out(input string tag, input bit big);
    int sz;
    sz = big ? out8.size() : out4.size();
    chk({tag, "_len"}, 64'(sz), 64'(want.size()));
    for (int i = 0; i < want.size(); i++)
      chk($sformatf("%s_item%0d", tag, i), (i < sz) ? (big ? out8[i] : out4[i]) : 'x, want[i]);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin p4[k] = 0; n4[k] = 0; end
    for (int k = 0; k < 8; k++) begin p8[k] = 0; n8[k] = 0; end
    drive();
    // Basic merge plus reset state
    hold4();
    load_std();
    go4();
    chk("rst_count", 64'(count4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    rst4 = 1'b0;
    chk("rst_write", 64'(wr4), 64'd0);
    chk("rst_read", 64'(rd4), 64'd0);
    rst4 = 1'b1;
    run4("basic", 60);
    want = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, T};
    check_out("basic", 0);
    chk("basic_first_write", 64'(first4), 64'd1);
    chk("basic_count", 64'(count4), 64'd8);
    // Ties drain the lower-index input first
    hold4();
    for (int k = 0; k < 4; k++) begin
      s4[k][0] = 32'd9; s4[k][1] = 32'd9; s4[k][2] = T; n4[k] = 3; p4[k] = 0;
    end
    drive();
    tie1 = -1;
    tie3 = -1;
    go4();
    run4("ties", 60);
    want = {32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, T};
    check_out("ties", 0);
    chk("ties_order01", 64'(tie1), 64'd2);
    chk("ties_order23", 64'(tie3), 64'd2);
    chk("ties_count", 64'(count4), 64'd8);
    // Backpressure
    hold4();
    load_std();
    rdy4 = 1'b0;
    go4();
    repeat (20) tick();
    chk("bp_no_writes", 64'(out4.size()), 64'd0);
    chk("bp_lvl2", 64'(lvl4[2]), 64'd4);
    chk("bp_lvl3", 64'(lvl4[3]), 64'd4);
    chk("bp_leaf_reads", 64'(rd4), 64'd0);
    chk("bp_write", 64'(wr4), 64'd0);
    rdy4 = 1'b1;
    run4("bp", 60);
    want = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, T};
    check_out("bp", 0);
    chk("bp_overflow4", 64'(ovf4), 64'd0);
    // Stream 2 holds only its terminator
    hold4();
    load_std();
    s4[2][0] = T;
    n4[2] = 1;
    drive();
    go4();
    run4("empty", 60);
    want = {32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd8, T};
    check_out("empty", 0);
    chk("empty_count", 64'(count4), 64'd6);
    // Reset after three outputs, then a clean rerun
    hold4();
    load_std();
    go4();
    for (int c = 0; c < 30 && out4.size() < 3; c++) tick();
    chk("mid_outputs", 64'(out4.size()), 64'd3);
    rst4 = 1'b0;
    tick();
    chk("mid_count", 64'(count4), 64'd0);
    chk("mid_done", 64'(done4), 64'd0);
    chk("mid_write", 64'(wr4), 64'd0);
    chk("mid_lvl2", 64'(lvl4[2]), 64'd0);
    chk("mid_lvl3", 64'(lvl4[3]), 64'd0);
    load_std();
    go4();
    run4("rerun", 60);
    want = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, T};
    check_out("rerun", 0);
    chk("rerun_count", 64'(count4), 64'd8);
    chk("overflow4", 64'(ovf4), 64'd0);
    // Eight random sorted streams, random output readiness
    want.delete();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] v;
      v = 32'($urandom_range(0, 20));
      for (int i = 0; i < 16; i++) begin
        s8[k][i] = v;
        want.push_back(v);
        v = v + 32'($urandom_range(0, 3));
      end
      s8[k][16] = T;
      n8[k] = 17;
      p8[k] = 0;
    end
    want.sort();
    want.push_back(T);
    drive();
    tick();
    rnd8 = 1;
    rdy8 = 1'b1;
    rst8 = 1'b1;
    since8 = 0;
    first8 = -1;
    out8.delete();
    for (int c = 0; c < 3000 && done8 !== 1'b1; c++) tick();
    chk("l8_done", 64'(done8), 64'd1);
    rdy8 = 1'b1;
    rnd8 = 0;
    repeat (4) tick();
    check_out("l8", 1);
    chk("l8_first_write", 64'(first8), 64'd2);
    chk("l8_count", 64'(count8), 64'd128);
    chk("overflow8", 64'(ovf8), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
